// File: rtl/uart_framer_pkg.sv
// uart_framer_pkg: shared constants and types for the uart_rx_framer slice.
// SOF byte, FSM state enum, err_code values, saturating counter helper.
package uart_framer_pkg;

  localparam logic [7:0] SOF = 8'h7E;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_framer_outreg.sv
// uart_rx_framer_outreg: one-deep valid/ready byte register with
// first/last sideband; load may coincide with a drain.
module uart_rx_framer_outreg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       first,
  input  logic       last,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_first,
  output logic       out_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
      out_first <= first;
      out_last  <= last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: SOF/LEN/payload/CSUM deframer behind a uartx2 rx port.
// Optional inter-byte timeout enabled by UART_RX_FRAMER_TIMEOUT_EN.
module uart_rx_framer
  import uart_framer_pkg::*;
#(
  parameter int          MAX_LEN        = 64,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rxdata,
  output logic        read_rx,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] sum;
  logic [7:0] remaining;
  logic [7:0] csum_total;
  logic       first_pend;
  logic       can_pop;
  logic       load;
  logic       timeout_hit;

  // In PAYLOAD the register must be free by the time the popped byte lands.
  assign can_pop    = (state != PAYLOAD) || !out_valid || out_ready;
  assign load       = read_rx && (state == PAYLOAD);
  assign csum_total = sum + rxdata;

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  logic [15:0] idle;
  logic        stalled;

  assign stalled     = out_valid && !out_ready;
  assign timeout_hit = (state != HUNT) && !read_rx && !stalled &&
                       (idle == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle <= 16'd0;
    else if (state == HUNT || read_rx || stalled || timeout_hit)
      idle <= 16'd0;
    else
      idle <= idle + 16'd1;
  end
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 16'd0);
`endif

  uart_rx_framer_outreg u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (rxdata),
    .first     (first_pend),
    .last      (remaining == 8'd1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      read_rx    <= 1'b0;
      sum        <= 8'h00;
      remaining  <= 8'h00;
      first_pend <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_NONE;
      frames_ok  <= 16'd0;
      frames_bad <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      read_rx    <= rx_valid && !read_rx && can_pop;
      if (timeout_hit) begin
        state      <= HUNT;
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        err_code   <= ERR_TIMEOUT;
        frames_bad <= sat_inc(frames_bad);
      end else if (read_rx) begin
        unique case (state)
          HUNT: begin
            if (rxdata == SOF) begin
              state <= LEN;
              sum   <= 8'h00;
            end
          end
          LEN: begin
            sum <= rxdata;
            if (rxdata == 8'h00) begin
              state <= CSUM;
            end else if (rxdata > MAX_B) begin
              state      <= HUNT;
              frame_done <= 1'b1;
              frame_ok   <= 1'b0;
              err_code   <= ERR_LEN;
              frames_bad <= sat_inc(frames_bad);
            end else begin
              remaining  <= rxdata;
              first_pend <= 1'b1;
              state      <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            sum        <= csum_total;
            remaining  <= remaining - 8'd1;
            first_pend <= 1'b0;
            if (remaining == 8'd1) state <= CSUM;
          end
          CSUM: begin
            state      <= HUNT;
            frame_done <= 1'b1;
            if (csum_total == 8'h00) begin
              frame_ok  <= 1'b1;
              err_code  <= ERR_NONE;
              frames_ok <= sat_inc(frames_ok);
            end else begin
              frame_ok   <= 1'b0;
              err_code   <= ERR_CSUM;
              frames_bad <= sat_inc(frames_bad);
            end
          end
        endcase
      end
    end
  end

endmodule
